// File: rtl/imm_extend_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_if
// Handshake bundle between decode (producer), the immediate-extension unit and
// the ALU/PC-target operand muxes (consumer).
//
// Signals:
//   in_valid        producer offers an immediate this cycle
//   in_ready        extension unit can accept an immediate this cycle
//   ExtMode         3-bit extension mode
//   immediate       raw IN_W-bit immediate field
//   in_tag          sideband tag travelling with the immediate
//   out_valid       ExtendImmediate/out_tag/illegal_mode hold a valid result
//   out_ready       consumer takes the result this cycle
//   ExtendImmediate OUT_W-bit extended value
//   out_tag         tag that travels with the result
//   illegal_mode    result came from an unsupported ExtMode
//
// Modports:
//   slave  - the extension unit
//   master - the environment around it (producer and consumer side)
// -----------------------------------------------------------------------------
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ExtMode;
  logic [IN_W-1:0]  immediate;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ExtendImmediate;
  logic [TAG_W-1:0] out_tag;
  logic             illegal_mode;

  modport slave (
    input  in_valid, ExtMode, immediate, in_tag, out_ready,
    output in_ready, out_valid, ExtendImmediate, out_tag, illegal_mode
  );

  modport master (
    output in_valid, ExtMode, immediate, in_tag, out_ready,
    input  in_ready, out_valid, ExtendImmediate, out_tag, illegal_mode
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit for the multi-cycle MIPS datapath.
// Widens an IN_W-bit immediate to OUT_W bits (zero / sign / upper / branch
// offset) and presents it behind a valid/ready handshake. A one-entry skid
// buffer sits beside the output register so consumer stalls never drop or
// duplicate a result; in_ready is registered and never depends on out_ready
// combinationally.
//
// Ports:
//   CLK    rising-edge clock
//   Reset  synchronous, active-high reset
//   bus    imm_extend_pipe_if.slave (handshake, immediate, tag, result)
//
// Mode encodings (ExtMode):
//   000 zero, 001 sign, 010 upper (imm << OUT_W-IN_W),
//   011 branch (sign-extend then << 2), 1xx illegal (result 0, flag set)
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  imm_extend_pipe_if.slave  bus
);

  function automatic logic [OUT_W-1:0] extend_imm(input logic [2:0]      mode,
                                                  input logic [IN_W-1:0] imm);
    logic [OUT_W-1:0] sx;
    sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      3'b000:  return {{(OUT_W-IN_W){1'b0}}, imm};
      3'b001:  return sx;
      3'b010:  return {imm, {(OUT_W-IN_W){1'b0}}};
      // Top two bits of the sign-extended value fall off the end.
      3'b011:  return {sx[OUT_W-3:0], 2'b00};
      default: return '0;
    endcase
  endfunction

  function automatic logic mode_illegal(input logic [2:0] mode);
    return mode[2];
  endfunction

  // Stage p0: combinational extension of the offered immediate
  logic [OUT_W-1:0] w_ext_p0;
  logic             w_ill_p0;
  logic             w_acc_p0;
  logic             w_out_free;

  // Stage p1: output register and skid buffer
  logic             r_in_ready;
  logic             r_out_vld_p1;
  logic [OUT_W-1:0] r_out_data_p1;
  logic [TAG_W-1:0] r_out_tag_p1;
  logic             r_out_ill_p1;
  logic             r_skid_vld_p1;
  logic [OUT_W-1:0] r_skid_data_p1;
  logic [TAG_W-1:0] r_skid_tag_p1;
  logic             r_skid_ill_p1;

  logic             w_out_vld_nxt;
  logic [OUT_W-1:0] w_out_data_nxt;
  logic [TAG_W-1:0] w_out_tag_nxt;
  logic             w_out_ill_nxt;
  logic             w_skid_vld_nxt;
  logic [OUT_W-1:0] w_skid_data_nxt;
  logic [TAG_W-1:0] w_skid_tag_nxt;
  logic             w_skid_ill_nxt;

  assign w_ext_p0   = extend_imm(bus.ExtMode, bus.immediate);
  assign w_ill_p0   = mode_illegal(bus.ExtMode);
  assign w_acc_p0   = bus.in_valid && r_in_ready;
  assign w_out_free = !r_out_vld_p1 || bus.out_ready;

  always_comb begin
    w_out_vld_nxt   = r_out_vld_p1;
    w_out_data_nxt  = r_out_data_p1;
    w_out_tag_nxt   = r_out_tag_p1;
    w_out_ill_nxt   = r_out_ill_p1;
    w_skid_vld_nxt  = r_skid_vld_p1;
    w_skid_data_nxt = r_skid_data_p1;
    w_skid_tag_nxt  = r_skid_tag_p1;
    w_skid_ill_nxt  = r_skid_ill_p1;

    if (w_out_free) begin
      if (r_skid_vld_p1) begin
        // Older skid entry goes out first; a concurrent accept refills the skid.
        w_out_vld_nxt  = 1'b1;
        w_out_data_nxt = r_skid_data_p1;
        w_out_tag_nxt  = r_skid_tag_p1;
        w_out_ill_nxt  = r_skid_ill_p1;
        w_skid_vld_nxt = w_acc_p0;
        if (w_acc_p0) begin
          w_skid_data_nxt = w_ext_p0;
          w_skid_tag_nxt  = bus.in_tag;
          w_skid_ill_nxt  = w_ill_p0;
        end
      end else begin
        // Empty output keeps its last payload; only valid drops.
        w_out_vld_nxt = w_acc_p0;
        if (w_acc_p0) begin
          w_out_data_nxt = w_ext_p0;
          w_out_tag_nxt  = bus.in_tag;
          w_out_ill_nxt  = w_ill_p0;
        end
      end
    end else if (w_acc_p0) begin
      w_skid_vld_nxt  = 1'b1;
      w_skid_data_nxt = w_ext_p0;
      w_skid_tag_nxt  = bus.in_tag;
      w_skid_ill_nxt  = w_ill_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_in_ready    <= 1'b1;
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
      r_out_tag_p1  <= '0;
      r_out_ill_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else begin
      // Registered ready: open exactly when the skid will be empty.
      r_in_ready    <= !w_skid_vld_nxt;
      r_out_vld_p1  <= w_out_vld_nxt;
      r_out_data_p1 <= w_out_data_nxt;
      r_out_tag_p1  <= w_out_tag_nxt;
      r_out_ill_p1  <= w_out_ill_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
    end
  end

  // Skid payload is qualified by r_skid_vld_p1, so it needs no reset.
  always_ff @(posedge CLK) begin
    r_skid_data_p1 <= w_skid_data_nxt;
    r_skid_tag_p1  <= w_skid_tag_nxt;
    r_skid_ill_p1  <= w_skid_ill_nxt;
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.out_valid       = r_out_vld_p1;
  assign bus.ExtendImmediate = r_out_data_p1;
  assign bus.out_tag         = r_out_tag_p1;
  assign bus.illegal_mode    = r_out_ill_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
// Scoreboard bench for imm_extend_pipe: accepted immediates push their expected
// result into a queue, a separate monitor pops and compares on every output
// transfer. Expected values come from an arithmetic reference model or, for
// the directed vectors, from hard-coded constants.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en  = 1'b0;
  bit   dir_use = 1'b0;
  exp_t dir_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2**OUT_W.
  function automatic exp_t model(input logic [2:0] mode, input logic [IN_W-1:0] imm,
                                 input logic [TAG_W-1:0] tag);
    longint u, s, m, r;
    exp_t   e;
    u = longint'(imm);
    s = u;
    m = (longint'(1) << OUT_W) - 1;
    if (u >= (longint'(1) << (IN_W-1))) s = u - (longint'(1) << IN_W);
    case (mode)
      3'd0:    r = u;
      3'd1:    r = s & m;
      3'd2:    r = (u * (longint'(1) << (OUT_W-IN_W))) & m;
      3'd3:    r = (s * 4) & m;
      default: r = 0;
    endcase
    e.data = r[OUT_W-1:0];
    e.tag  = tag;
    e.ill  = mode[2];
    return e;
  endfunction

  // Acceptance side: occupancy checks, then push expected result.
  always @(negedge CLK) begin
    int occ;
    occ = q.size();
    if (chk_en) begin
      chk("out_valid_vs_occupancy", 64'(bus.out_valid), 64'(occ > 0));
      chk("in_ready_vs_occupancy", 64'(bus.in_ready), 64'(occ < 2));
    end
    if (Reset) q.delete();
    else if (bus.in_valid && bus.in_ready)
      q.push_back(dir_use ? dir_exp : model(bus.ExtMode, bus.immediate, bus.in_tag));
  end

  // Output monitor: stall stability, X check, pop-and-compare.
  bit               stalled_prev = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ill;
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (chk_en && !Reset) begin
      if (stalled_prev) begin
        chk("stall_data", 64'(bus.ExtendImmediate), 64'(prev_data));
        chk("stall_tag", 64'(bus.out_tag), 64'(prev_tag));
        chk("stall_ill", 64'(bus.illegal_mode), 64'(prev_ill));
      end
      if (bus.out_valid)
        chk("out_no_x", 64'($isunknown({bus.ExtendImmediate, bus.out_tag, bus.illegal_mode})), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("data", 64'(bus.ExtendImmediate), 64'(e.data));
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          chk("illegal", 64'(bus.illegal_mode), 64'(e.ill));
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_data    = bus.ExtendImmediate;
      prev_tag     = bus.out_tag;
      prev_ill     = bus.illegal_mode;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  // Holds one directed item until accepted, with a hard-coded expectation.
  task automatic send_dir(input logic [2:0] mode, input logic [IN_W-1:0] imm,
                          input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] d,
                          input logic ill);
    bit acc;
    int n;
    dir_use       = 1'b1;
    dir_exp.data  = d;
    dir_exp.tag   = tag;
    dir_exp.ill   = ill;
    bus.in_valid  = 1'b1;
    bus.ExtMode   = mode;
    bus.immediate = imm;
    bus.in_tag    = tag;
    acc = 1'b0;
    n   = 0;
    do begin
      @(negedge CLK);
      acc = bus.in_ready;
      next_cyc();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("directed_accept_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
    dir_use      = 1'b0;
  endtask

  task automatic drive_random_item();
    bus.ExtMode   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    bus.immediate = IN_W'($urandom);
  endtask

  initial begin
    int tagv, c, items, n;
    Reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ExtMode   = '0;
    bus.immediate = '0;
    bus.in_tag    = '0;
    next_cyc();
    next_cyc();
    Reset  = 1'b0;
    chk_en = 1'b1;
    next_cyc();

    // Directed vectors, consumer always ready.
    bus.out_ready = 1'b1;
    send_dir(3'b001, 16'h8001, 5'd3, 32'hFFFF8001, 1'b0);
    send_dir(3'b000, 16'h8001, 5'd4, 32'h00008001, 1'b0);
    send_dir(3'b010, 16'h1234, 5'd5, 32'h12340000, 1'b0);
    send_dir(3'b011, 16'hFFFF, 5'd6, 32'hFFFFFFFC, 1'b0);
    send_dir(3'b011, 16'h7FFF, 5'd7, 32'h0001FFFC, 1'b0);
    send_dir(3'b101, 16'hABCD, 5'd8, 32'h00000000, 1'b1);
    repeat (3) next_cyc();

    // Backpressure: tags 1..6 back to back, consumer stalled in cycles 2..5.
    tagv = 1;
    c    = 1;
    while ((tagv <= 6 || q.size() != 0) && c < 100) begin
      bus.out_ready = !(c >= 2 && c <= 5);
      bus.in_valid  = (tagv <= 6);
      bus.in_tag    = TAG_W'(tagv);
      drive_random_item();
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready) tagv++;
      next_cyc();
      c++;
    end
    chk("backpressure_all_accepted", 64'(tagv), 64'(7));
    bus.in_valid = 1'b0;
    next_cyc();

    // Reset with output and skid both full, plus data offered during reset.
    bus.out_ready = 1'b0;
    items = 0;
    n     = 0;
    while (items < 2 && n < 20) begin
      bus.in_valid = 1'b1;
      bus.in_tag   = TAG_W'(20 + items);
      drive_random_item();
      @(negedge CLK);
      if (bus.in_ready) items++;
      next_cyc();
      n++;
    end
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("full_in_ready_low", 64'(bus.in_ready), 64'(0));
    next_cyc();
    Reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd31;
    next_cyc();
    Reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("post_reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
    next_cyc();
    bus.out_ready = 1'b1;
    send_dir(3'b001, 16'h0005, 5'd9, 32'h00000005, 1'b0);
    @(negedge CLK);
    chk("post_reset_latency", 64'(bus.out_valid), 64'(1));
    next_cyc();

    // Randomised valid/ready traffic, all modes.
    items = 0;
    c     = 0;
    while (items < 10000 && c < 60000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_tag    = TAG_W'($urandom);
      drive_random_item();
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready) items++;
      next_cyc();
      c++;
    end
    chk("random_items_accepted", 64'(items), 64'(10000));

    // Drain.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      next_cyc();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
